// File: rtl/mtpsa_bridge_pkg.sv
// Shared types and defaults for the SUME-to-SDNet packet-boundary bridge.
package mtpsa_bridge_pkg;

   typedef enum logic {
      FIRST = 1'b0,
      WAIT  = 1'b1
   } chan_state_e;

   localparam int unsigned NUM_CH_DEFAULT    = 8;
   localparam int unsigned CNT_WIDTH_DEFAULT = 32;
   localparam int unsigned MAX_BEATS_DEFAULT = 512;

endpackage

// File: rtl/mtpsa_bridge_chan.sv
// One stream channel: SOP/EOP tracking, tuple strobe, beat watchdog and packet statistics.
module mtpsa_bridge_chan
   import mtpsa_bridge_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
   parameter int unsigned MAX_BEATS = MAX_BEATS_DEFAULT
) (
   input  logic                 axis_aclk,
   input  logic                 axis_reset,
   input  logic                 tvalid,
   input  logic                 tlast,
   input  logic                 tready,
   input  logic                 clr_stats,
   output logic                 tuple_valid_c,
   output logic                 tlast_c,
   output logic                 in_packet,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic                 err_oversize
);

   localparam int unsigned       BEAT_W   = $clog2(MAX_BEATS + 1);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);

   chan_state_e          state, state_nxt;
   logic [BEAT_W-1:0]    beat_cnt, beat_nxt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 err_nxt;
   logic                 acc;

   assign acc       = tvalid & tready;
   assign in_packet = (state == WAIT);
   assign tlast_c   = tvalid & tlast & ~axis_reset;

   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) begin
         state        <= FIRST;
         beat_cnt     <= '0;
         pkt_count    <= '0;
         err_oversize <= 1'b0;
      end else begin
         state        <= state_nxt;
         beat_cnt     <= beat_nxt;
         pkt_count    <= cnt_nxt;
         err_oversize <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      beat_nxt      = beat_cnt;
      cnt_nxt       = pkt_count;
      err_nxt       = err_oversize;
      tuple_valid_c = 1'b0;

      case (state)
         FIRST: begin
            if (acc) begin
               tuple_valid_c = ~axis_reset;
               if (tlast) begin
                  cnt_nxt = pkt_count + CNT_WIDTH'(1);
               end else begin
                  state_nxt = WAIT;
                  beat_nxt  = BEAT_W'(1);
               end
            end
         end
         WAIT: begin
            if (acc) begin
               // A beat arriving with the counter already at the limit is one too many.
               if (beat_cnt == BEAT_MAX) begin
                  err_nxt = 1'b1;
               end
               if (tlast) begin
                  state_nxt = FIRST;
                  beat_nxt  = '0;
                  cnt_nxt   = pkt_count + CNT_WIDTH'(1);
               end else if (beat_cnt != BEAT_MAX) begin
                  beat_nxt = beat_cnt + BEAT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = FIRST;
         end
      endcase

      // Statistics clear wins over any same-cycle count or flag update.
      if (clr_stats) begin
         cnt_nxt = '0;
         err_nxt = 1'b0;
      end
   end

endmodule

// File: rtl/mtpsa_to_sdnet_mc.sv
// Multi-channel SUME AXI-Stream to per-tenant SDNet boundary bridge.
module mtpsa_to_sdnet_mc
   import mtpsa_bridge_pkg::*;
#(
   parameter int unsigned NUM_CH    = NUM_CH_DEFAULT,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
   parameter int unsigned MAX_BEATS = MAX_BEATS_DEFAULT
) (
   input  logic                        axis_aclk,
   input  logic                        axis_reset,
   input  logic [NUM_CH-1:0]           SUME_axis_tvalid,
   input  logic [NUM_CH-1:0]           SUME_axis_tlast,
   input  logic [NUM_CH-1:0]           SUME_axis_tready,
   input  logic                        clr_stats,
   output logic [NUM_CH-1:0]           SDNet_tuple_VALID,
   output logic [NUM_CH-1:0]           SDNet_axis_TLAST,
   output logic [NUM_CH-1:0]           in_packet,
   output logic [NUM_CH*CNT_WIDTH-1:0] pkt_count,
   output logic [NUM_CH-1:0]           err_oversize
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mtpsa_bridge_chan #(
         .CNT_WIDTH (CNT_WIDTH),
         .MAX_BEATS (MAX_BEATS)
      ) u_chan (
         .axis_aclk     (axis_aclk),
         .axis_reset    (axis_reset),
         .tvalid        (SUME_axis_tvalid[i]),
         .tlast         (SUME_axis_tlast[i]),
         .tready        (SUME_axis_tready[i]),
         .clr_stats     (clr_stats),
         .tuple_valid_c (SDNet_tuple_VALID[i]),
         .tlast_c       (SDNet_axis_TLAST[i]),
         .in_packet     (in_packet[i]),
         .pkt_count     (pkt_count[i*CNT_WIDTH +: CNT_WIDTH]),
         .err_oversize  (err_oversize[i])
      );
   end

endmodule

// File: tb/tb_mtpsa_to_sdnet_mc.sv
// Scoreboard bench for mtpsa_to_sdnet_mc built with MAX_BEATS=4 and 4-bit packet counters.
module tb_mtpsa_to_sdnet_mc;

   localparam int unsigned NCH = 8;
   localparam int unsigned CW  = 4;
   localparam int unsigned MB  = 4;

   logic              axis_aclk;
   logic              axis_reset;
   logic [NCH-1:0]    SUME_axis_tvalid;
   logic [NCH-1:0]    SUME_axis_tlast;
   logic [NCH-1:0]    SUME_axis_tready;
   logic              clr_stats;
   logic [NCH-1:0]    SDNet_tuple_VALID;
   logic [NCH-1:0]    SDNet_axis_TLAST;
   logic [NCH-1:0]    in_packet;
   logic [NCH*CW-1:0] pkt_count;
   logic [NCH-1:0]    err_oversize;

   mtpsa_to_sdnet_mc #(
      .NUM_CH    (NCH),
      .CNT_WIDTH (CW),
      .MAX_BEATS (MB)
   ) dut (
      .axis_aclk         (axis_aclk),
      .axis_reset        (axis_reset),
      .SUME_axis_tvalid  (SUME_axis_tvalid),
      .SUME_axis_tlast   (SUME_axis_tlast),
      .SUME_axis_tready  (SUME_axis_tready),
      .clr_stats         (clr_stats),
      .SDNet_tuple_VALID (SDNet_tuple_VALID),
      .SDNet_axis_TLAST  (SDNet_axis_TLAST),
      .in_packet         (in_packet),
      .pkt_count         (pkt_count),
      .err_oversize      (err_oversize)
   );

   initial begin
      axis_aclk = 1'b0;
      forever #5 axis_aclk = ~axis_aclk;
   end

   // Observed view of one channel; stray flags activity on any other channel.
   typedef struct packed {
      logic          tuple;
      logic          tl;
      logic          inp;
      logic [CW-1:0] cnt;
      logic          err;
      logic          stray;
   } obs_t;

   typedef struct {
      int   ch;
      bit   tv, tl, tr, clr, rst;
      obs_t e;
   } row_t;

   typedef struct {
      string tag;
      int    ch;
      obs_t  v;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   function automatic row_t mk(int ch, bit tv, bit tl, bit tr, bit clr, bit rst,
                               bit et, bit etl, bit ein, int ec, bit ee);
      row_t r;
      r.ch = ch; r.tv = tv; r.tl = tl; r.tr = tr; r.clr = clr; r.rst = rst;
      r.e.tuple = et; r.e.tl = etl; r.e.inp = ein;
      r.e.cnt = CW'(ec); r.e.err = ee; r.e.stray = 1'b0;
      return r;
   endfunction

   function automatic row_t idle(int ch, bit ein, int ec, bit ee);
      return mk(ch, 0, 0, 0, 0, 0, 0, 0, ein, ec, ee);
   endfunction

   function automatic obs_t sample(int ch);
      obs_t           o;
      logic [NCH-1:0] other;
      other   = ~(NCH'(1) << ch);
      o.tuple = SDNet_tuple_VALID[ch];
      o.tl    = SDNet_axis_TLAST[ch];
      o.inp   = in_packet[ch];
      o.cnt   = pkt_count[ch*CW +: CW];
      o.err   = err_oversize[ch];
      o.stray = (|(SDNet_tuple_VALID & other)) | (|(SDNet_axis_TLAST & other));
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("tuple=%b tlast=%b in_packet=%b count=%0d err=%b stray=%b",
                       o.tuple, o.tl, o.inp, o.cnt, o.err, o.stray);
   endfunction

   // Drive one cycle mid-period and queue the expected observation for it.
   task automatic drive(input row_t r, input string tag);
      exp_t x;
      @(negedge axis_aclk);
      SUME_axis_tvalid       = '0;
      SUME_axis_tlast        = '0;
      SUME_axis_tready       = '0;
      SUME_axis_tvalid[r.ch] = r.tv;
      SUME_axis_tlast[r.ch]  = r.tl;
      SUME_axis_tready[r.ch] = r.tr;
      clr_stats              = r.clr;
      axis_reset             = r.rst;
      x.tag = tag; x.ch = r.ch; x.v = r.e;
      exp_q.push_back(x);
      #1;
   endtask

   task automatic test_reset();
      row_t rows[$];
      exp_t e;
      obs_t got;
      rows.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      rows.push_back(idle(0, 0, 0, 0));
      foreach (rows[i]) begin
         drive(rows[i], "reset");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   task automatic test_four_beat();
      row_t rows[$];
      exp_t e;
      obs_t got;
      rows.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
      rows.push_back(idle(0, 0, 1, 0));
      foreach (rows[i]) begin
         drive(rows[i], "four_beat");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   task automatic test_single_beat();
      row_t rows[$];
      exp_t e;
      obs_t got;
      for (int k = 0; k < 3; k++) rows.push_back(mk(3, 1, 1, 1, 0, 0, 1, 1, 0, k, 0));
      rows.push_back(idle(3, 0, 3, 0));
      foreach (rows[i]) begin
         drive(rows[i], "single_beat");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   task automatic test_tready_toggle();
      row_t rows[$];
      exp_t e;
      obs_t got;
      rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));  // stray tlast, not accepted
      rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      rows.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
      rows.push_back(idle(1, 0, 1, 0));
      foreach (rows[i]) begin
         drive(rows[i], "tready_toggle");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   task automatic test_oversize();
      row_t rows[$];
      exp_t e;
      obs_t got;
      // Exactly MB beats is legal.
      rows.push_back(mk(4, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 2; k++) rows.push_back(mk(4, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(4, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
      rows.push_back(idle(4, 0, 1, 0));
      // Six beats: flag set by the fifth, visible from the sixth.
      rows.push_back(mk(4, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0));
      for (int k = 0; k < 4; k++) rows.push_back(mk(4, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0));
      rows.push_back(mk(4, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1));
      rows.push_back(idle(4, 0, 2, 1));
      rows.push_back(idle(4, 0, 2, 1));
      rows.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1));
      rows.push_back(idle(4, 0, 0, 0));
      // Five beats with tlast on the over-limit beat still flags.
      rows.push_back(mk(4, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++) rows.push_back(mk(4, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(4, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
      rows.push_back(idle(4, 0, 1, 1));
      rows.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
      rows.push_back(idle(4, 0, 0, 0));
      foreach (rows[i]) begin
         drive(rows[i], "oversize");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   task automatic test_clr_priority();
      row_t rows[$];
      exp_t e;
      obs_t got;
      for (int k = 0; k < 7; k++) rows.push_back(mk(2, 1, 1, 1, 0, 0, 1, 1, 0, k, 0));
      rows.push_back(mk(2, 1, 1, 1, 1, 0, 1, 1, 0, 7, 0));  // EOP discarded by clear
      rows.push_back(idle(2, 0, 0, 0));
      // Clear mid-packet leaves the FSM inside the packet.
      rows.push_back(mk(2, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(2, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(2, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
      rows.push_back(idle(2, 0, 1, 0));
      foreach (rows[i]) begin
         drive(rows[i], "clr_priority");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   task automatic test_wrap();
      row_t rows[$];
      exp_t e;
      obs_t got;
      for (int k = 0; k < 16; k++) rows.push_back(mk(6, 1, 1, 1, 0, 0, 1, 1, 0, k, 0));
      rows.push_back(idle(6, 0, 0, 0));
      foreach (rows[i]) begin
         drive(rows[i], "wrap");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   task automatic test_reset_mid_packet();
      row_t rows[$];
      exp_t e;
      obs_t got;
      rows.push_back(mk(5, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(5, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(5, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      rows.push_back(mk(5, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      rows.push_back(mk(5, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));  // beat 3 seen as SOP
      rows.push_back(mk(5, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      rows.push_back(mk(5, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
      rows.push_back(idle(5, 0, 1, 0));
      foreach (rows[i]) begin
         drive(rows[i], "reset_mid_packet");
         e = exp_q.pop_front();
         got = sample(e.ch);
         checks++;
         if (got !== e.v) $display("FAIL %s[%0d] got %s required %s", e.tag, i, fmt(got), fmt(e.v));
         else passes++;
      end
   endtask

   initial begin
      axis_reset       = 1'b1;
      clr_stats        = 1'b0;
      SUME_axis_tvalid = '0;
      SUME_axis_tlast  = '0;
      SUME_axis_tready = '0;
      test_reset();
      test_four_beat();
      test_single_beat();
      test_tready_toggle();
      test_oversize();
      test_clr_priority();
      test_wrap();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule
